// File: rtl/can_irq_pkg.sv
// Shared encodings for the CAN interrupt controller: register select codes,
// control bit positions and the pulse-mode FSM states.
package can_irq_pkg;

  localparam logic [1:0] SEL_IEN  = 2'd0;
  localparam logic [1:0] SEL_PEND = 2'd1;
  localparam logic [1:0] SEL_CTRL = 2'd2;

  localparam int CTRL_GIE   = 0;
  localparam int CTRL_PMODE = 1;
  localparam int CTRL_ONOFF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } irq_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_irq_ctrl_if.sv
// CPU/CAN-side bundle of the interrupt controller; the controller is the
// slave, the CPU/CAN core side is the master.
interface can_irq_ctrl_if
  import can_irq_pkg::*;
#(
  parameter int NSRC = 3
);
  localparam int ID_W = id_width(NSRC);

  logic            cpu_we;
  logic [1:0]      cpu_sel;
  logic [NSRC-1:0] cpu_wdata;
  logic            cpu_ack;
  logic [NSRC-1:0] can_evt;

  logic [NSRC-1:0] ien;
  logic [NSRC-1:0] pend;
  logic            gie;
  logic            pmode;
  logic            onoff;
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic            vec_valid;

  modport master (
    output cpu_we, cpu_sel, cpu_wdata, cpu_ack, can_evt,
    input  ien, pend, gie, pmode, onoff, irq, irq_id, vec_valid
  );

  modport slave (
    input  cpu_we, cpu_sel, cpu_wdata, cpu_ack, can_evt,
    output ien, pend, gie, pmode, onoff, irq, irq_id, vec_valid
  );

endinterface

// File: rtl/can_irq_prio_enc.sv
// Lowest-index-first priority encoder, purely combinational.
// id is 0 whenever valid is 0.
module can_irq_prio_enc
  import can_irq_pkg::*;
#(
  parameter  int NSRC = 3,
  localparam int ID_W = id_width(NSRC)
) (
  input  logic [NSRC-1:0] req,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_irq_ctrl.sv
// NSRC-source interrupt controller: pending/enable/control registers, a
// level or fixed-width pulse irq line, and a registered highest-priority vector.
module can_irq_ctrl
  import can_irq_pkg::*;
#(
  parameter int NSRC    = 3,
  parameter int PULSE_W = 4
) (
  input logic           clk,
  input logic           rst,
  can_irq_ctrl_if.slave bus
);

  localparam int ID_W  = id_width(NSRC);
  localparam int CNT_W = id_width(PULSE_W);

  logic [NSRC-1:0] ien;
  logic [NSRC-1:0] pend;
  logic [2:0]      ctrl;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] active_q;
  logic [NSRC-1:0] clr;
  logic            any;
  logic            new_evt;
  logic            abort;
  logic            wr_ien;
  logic            wr_pend;
  logic            wr_ctrl;
  logic [ID_W-1:0] enc_id;
  logic            enc_vld;
  logic [ID_W-1:0] irq_id_q;
  logic            vec_valid_q;
  logic            irq_q;
  logic            irq_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  irq_state_t      state;
  irq_state_t      state_n;

  assign wr_ien  = bus.cpu_we && (bus.cpu_sel == SEL_IEN);
  assign wr_pend = bus.cpu_we && (bus.cpu_sel == SEL_PEND);
  assign wr_ctrl = bus.cpu_we && (bus.cpu_sel == SEL_CTRL);

  assign active  = pend & ien;
  assign any     = ctrl[CTRL_GIE] & (|active);
  assign new_evt = ctrl[CTRL_GIE] & (|(active & ~active_q));

  // A mode change or gie drop kills any pulse in flight at the write edge.
  assign abort = wr_ctrl &&
                 ((bus.cpu_wdata[CTRL_PMODE] != ctrl[CTRL_PMODE]) || !bus.cpu_wdata[CTRL_GIE]);

  always_comb begin
    clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      clr[i] = (wr_pend & bus.cpu_wdata[i]) |
               (bus.cpu_ack & vec_valid_q & (irq_id_q == ID_W'(i)));
    end
  end

  can_irq_prio_enc #(.NSRC(NSRC)) u_enc (
    .req   (active),
    .id    (enc_id),
    .valid (enc_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ien         <= '0;
      pend        <= '0;
      ctrl        <= '0;
      active_q    <= '0;
      irq_id_q    <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      if (wr_ien)  ien  <= bus.cpu_wdata;
      if (wr_ctrl) ctrl <= bus.cpu_wdata[2:0];
      // Events are OR-ed in after the clear so a same-cycle set always wins.
      pend        <= bus.can_evt | (pend & ~clr);
      active_q    <= active;
      vec_valid_q <= any;
      irq_id_q    <= (any && enc_vld) ? enc_id : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      irq_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      irq_q <= irq_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    irq_n   = irq_q;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      irq_n   = 1'b0;
    end else if (!ctrl[CTRL_PMODE]) begin
      state_n = IDLE;
      cnt_n   = '0;
      irq_n   = any;
    end else begin
      unique case (state)
        IDLE: begin
          irq_n = 1'b0;
          if (new_evt) begin
            state_n = PULSE;
            cnt_n   = CNT_W'(PULSE_W - 1);
            irq_n   = 1'b1;
          end
        end
        PULSE: begin
          irq_n = 1'b1;
          if (cnt == '0) begin
            state_n = HOLD;
            irq_n   = 1'b0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          irq_n = 1'b0;
          if (new_evt) begin
            state_n = PULSE;
            cnt_n   = CNT_W'(PULSE_W - 1);
            irq_n   = 1'b1;
          end else if (!any) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          irq_n   = 1'b0;
        end
      endcase
    end
  end

  assign bus.ien       = ien;
  assign bus.pend      = pend;
  assign bus.gie       = ctrl[CTRL_GIE];
  assign bus.pmode     = ctrl[CTRL_PMODE];
  assign bus.onoff     = ctrl[CTRL_ONOFF];
  assign bus.irq       = irq_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.vec_valid = vec_valid_q;

endmodule

// File: tb/tb_can_irq_ctrl.sv
// Directed scoreboard bench for can_irq_ctrl with NSRC=3, PULSE_W=4.
module tb_can_irq_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  can_irq_ctrl_if #(.NSRC(3)) bus ();

  can_irq_ctrl #(.NSRC(3), .PULSE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected snapshot: {ien, pend, onoff/pmode/gie, irq, irq_id, vec_valid}
  typedef struct {
    int          cyc;
    string       nm;
    logic [13:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [13:0] act;

  task automatic chk(input string nm, input logic [2:0] ien, input logic [2:0] pnd,
                     input logic [2:0] ctl, input logic irq, input logic [1:0] id,
                     input logic vv, input int d = 0);
    exp_t x;
    x.cyc = cyc + d;
    x.nm  = nm;
    x.v   = {ien, pnd, ctl, irq, id, vv};
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    act = {bus.ien, bus.pend, bus.onoff, bus.pmode, bus.gie, bus.irq, bus.irq_id, bus.vec_valid};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      total++;
      if (e.cyc != cyc || act !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d: got ien/pend/ctrl/irq/id/vv=%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
                 e.nm, cyc, act[13:11], act[10:8], act[7:5], act[4], act[3:2], act[1],
                 e.v[13:11], e.v[10:8], e.v[7:5], e.v[4], e.v[3:2], e.v[1]);
      end
    end
  end

  // Drive one cycle of inputs, wait past the edge, return inputs to idle.
  task automatic step(input logic we, input logic [1:0] sel, input logic [2:0] wd,
                      input logic ack, input logic [2:0] evt);
    bus.cpu_we    = we;
    bus.cpu_sel   = sel;
    bus.cpu_wdata = wd;
    bus.cpu_ack   = ack;
    bus.can_evt   = evt;
    @(posedge clk);
    #1;
    bus.cpu_we    = 1'b0;
    bus.cpu_sel   = 2'd0;
    bus.cpu_wdata = 3'd0;
    bus.cpu_ack   = 1'b0;
    bus.can_evt   = 3'd0;
  endtask

  task automatic idle();          step(1'b0, 2'd0, 3'd0, 1'b0, 3'd0); endtask
  task automatic wr(input logic [1:0] s, input logic [2:0] d); step(1'b1, s, d, 1'b0, 3'd0); endtask
  task automatic ev(input logic [2:0] x); step(1'b0, 2'd0, 3'd0, 1'b0, x); endtask
  task automatic ack();           step(1'b0, 2'd0, 3'd0, 1'b1, 3'd0); endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_sel = 2'd0; bus.cpu_wdata = 3'd0;
    bus.cpu_ack = 1'b0; bus.can_evt = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;

    // Level mode basics
    wr(2'd0, 3'b111);  chk("lv_ien",  3'd7, 3'd0, 3'd1 & 3'd0, 1'b0, 2'd0, 1'b0);
    wr(2'd2, 3'b001);  chk("lv_ctrl", 3'd7, 3'd0, 3'd1, 1'b0, 2'd0, 1'b0);
    ev(3'b100);        chk("lv_evt",  3'd7, 3'd4, 3'd1, 1'b0, 2'd0, 1'b0);
    idle();            chk("lv_irq",  3'd7, 3'd4, 3'd1, 1'b1, 2'd2, 1'b1);
    wr(2'd1, 3'b100);  chk("lv_w1c",  3'd7, 3'd0, 3'd1, 1'b1, 2'd2, 1'b1);
    idle();            chk("lv_clr",  3'd7, 3'd0, 3'd1, 1'b0, 2'd0, 1'b0);

    // Set beats clear
    ev(3'b010);                               chk("rc_set",  3'd7, 3'd2, 3'd1, 1'b0, 2'd0, 1'b0);
    idle();                                   chk("rc_irq",  3'd7, 3'd2, 3'd1, 1'b1, 2'd1, 1'b1);
    step(1'b1, 2'd1, 3'b010, 1'b0, 3'b010);   chk("rc_w1c",  3'd7, 3'd2, 3'd1, 1'b1, 2'd1, 1'b1);
    step(1'b0, 2'd0, 3'b000, 1'b1, 3'b010);   chk("rc_ack",  3'd7, 3'd2, 3'd1, 1'b1, 2'd1, 1'b1);
    ack();                                    chk("rc_ack2", 3'd7, 3'd0, 3'd1, 1'b1, 2'd1, 1'b1);
    idle();                                   chk("rc_done", 3'd7, 3'd0, 3'd1, 1'b0, 2'd0, 1'b0);

    // Priority and acknowledge-by-ID
    ev(3'b110);  chk("pr_set",  3'd7, 3'd6, 3'd1, 1'b0, 2'd0, 1'b0);
    idle();      chk("pr_id1",  3'd7, 3'd6, 3'd1, 1'b1, 2'd1, 1'b1);
    ack();       chk("pr_ack1", 3'd7, 3'd4, 3'd1, 1'b1, 2'd1, 1'b1);
    idle();      chk("pr_id2",  3'd7, 3'd4, 3'd1, 1'b1, 2'd2, 1'b1);
    ack();       chk("pr_ack2", 3'd7, 3'd0, 3'd1, 1'b1, 2'd2, 1'b1);
    idle();      chk("pr_done", 3'd7, 3'd0, 3'd1, 1'b0, 2'd0, 1'b0);
    ev(3'b001);  chk("ak_set",  3'd7, 3'd1, 3'd1, 1'b0, 2'd0, 1'b0);
    ack();       chk("ak_ign",  3'd7, 3'd1, 3'd1, 1'b1, 2'd0, 1'b1);
    ack();       chk("ak_clr",  3'd7, 3'd0, 3'd1, 1'b1, 2'd0, 1'b1);
    idle();      chk("ak_done", 3'd7, 3'd0, 3'd1, 1'b0, 2'd0, 1'b0);

    // Pulse mode
    wr(2'd2, 3'b011);  chk("pm_ctrl", 3'd7, 3'd0, 3'd3, 1'b0, 2'd0, 1'b0);
    ev(3'b001);        chk("pm_evt",  3'd7, 3'd1, 3'd3, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();          chk("pm_hi",   3'd7, 3'd1, 3'd3, 1'b1, 2'd0, 1'b1);
    end
    idle();            chk("pm_end",  3'd7, 3'd1, 3'd3, 1'b0, 2'd0, 1'b1);
    ev(3'b001);        chk("pm_re",   3'd7, 3'd1, 3'd3, 1'b0, 2'd0, 1'b1);
    idle();            chk("pm_nonew",3'd7, 3'd1, 3'd3, 1'b0, 2'd0, 1'b1);
    ev(3'b100);        chk("pm_evt2", 3'd7, 3'd5, 3'd3, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle();          chk("pm_hi2",  3'd7, 3'd5, 3'd3, 1'b1, 2'd0, 1'b1);
    end
    idle();            chk("pm_end2", 3'd7, 3'd5, 3'd3, 1'b0, 2'd0, 1'b1);
    wr(2'd1, 3'b101);  chk("pm_w1c",  3'd7, 3'd0, 3'd3, 1'b0, 2'd0, 1'b1);
    idle();            chk("pm_idle", 3'd7, 3'd0, 3'd3, 1'b0, 2'd0, 1'b0);

    // Masking in pulse mode, then gie drop mid-pulse
    wr(2'd0, 3'b000);  chk("mk_ien0",   3'd0, 3'd0, 3'd3, 1'b0, 2'd0, 1'b0);
    ev(3'b001);        chk("mk_evt",    3'd0, 3'd1, 3'd3, 1'b0, 2'd0, 1'b0);
    idle();            chk("mk_masked", 3'd0, 3'd1, 3'd3, 1'b0, 2'd0, 1'b0);
    wr(2'd0, 3'b001);  chk("mk_ien1",   3'd1, 3'd1, 3'd3, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();          chk("mk_hi",     3'd1, 3'd1, 3'd3, 1'b1, 2'd0, 1'b1);
    end
    idle();            chk("mk_end",    3'd1, 3'd1, 3'd3, 1'b0, 2'd0, 1'b1);
    wr(2'd0, 3'b011);  chk("mk_ien3",   3'd3, 3'd1, 3'd3, 1'b0, 2'd0, 1'b1);
    ev(3'b010);        chk("mk_evt1",   3'd3, 3'd3, 3'd3, 1'b0, 2'd0, 1'b1);
    idle();            chk("mk_new",    3'd3, 3'd3, 3'd3, 1'b1, 2'd0, 1'b1);
    wr(2'd2, 3'b010);  chk("mk_gie0",   3'd3, 3'd3, 3'd2, 1'b0, 2'd0, 1'b1);
    idle();            chk("mk_off",    3'd3, 3'd3, 3'd2, 1'b0, 2'd0, 1'b0);

    // Masking in level mode
    wr(2'd2, 3'b001);  chk("lm_ctrl",   3'd3, 3'd3, 3'd1, 1'b0, 2'd0, 1'b0);
    idle();            chk("lm_irq",    3'd3, 3'd3, 3'd1, 1'b1, 2'd0, 1'b1);
    wr(2'd0, 3'b000);  chk("lm_mask",   3'd0, 3'd3, 3'd1, 1'b1, 2'd0, 1'b1);
    idle();            chk("lm_masked", 3'd0, 3'd3, 3'd1, 1'b0, 2'd0, 1'b0);
    wr(2'd0, 3'b010);  chk("lm_ien1",   3'd2, 3'd3, 3'd1, 1'b0, 2'd0, 1'b0);
    idle();            chk("lm_unmask", 3'd2, 3'd3, 3'd1, 1'b1, 2'd1, 1'b1);
    wr(2'd2, 3'b101);  chk("onoff",     3'd2, 3'd3, 3'd5, 1'b1, 2'd1, 1'b1);

    // Reset in the middle of a pulse
    wr(2'd2, 3'b011);  chk("rp_ctrl",  3'd2, 3'd3, 3'd3, 1'b0, 2'd1, 1'b1);
    wr(2'd1, 3'b011);  chk("rp_w1c",   3'd2, 3'd0, 3'd3, 1'b0, 2'd1, 1'b1);
    idle();            chk("rp_clr",   3'd2, 3'd0, 3'd3, 1'b0, 2'd0, 1'b0);
    ev(3'b010);        chk("rp_evt",   3'd2, 3'd2, 3'd3, 1'b0, 2'd0, 1'b0);
    idle();            chk("rp_hi",    3'd2, 3'd2, 3'd3, 1'b1, 2'd1, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("rp_async", 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    idle();            chk("rp_rel",   3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
    wr(2'd0, 3'b111);  chk("rp_ien",   3'd7, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
    wr(2'd2, 3'b011);  chk("rp_ctl2",  3'd7, 3'd0, 3'd3, 1'b0, 2'd0, 1'b0);
    ev(3'b001);        chk("rp_evt2",  3'd7, 3'd1, 3'd3, 1'b0, 2'd0, 1'b0);
    idle();            chk("rp_new",   3'd7, 3'd1, 3'd3, 1'b1, 2'd0, 1'b1);

    idle();
    idle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_irq_ctrl.md
Name: can_irq_ctrl

Overview:
Parametrised interrupt controller for the CAN core; successor to the fixed 3-source interrupt register.
- Holds per-source pending and enable bits for NSRC sources, plus a control register (global enable, output mode, on/off).
- Drives a single CPU interrupt line in level or fixed-width pulse mode.
- Presents the highest-priority active source ID and supports acknowledge-by-ID.

Parameters:
NSRC, 3, number of interrupt sources (3..16); source 0 has highest priority
PULSE_W, 4, irq high time in clk cycles in pulse mode (>=1)
ID_W, $clog2(NSRC) (min 1), derived localparam, width of irq_id

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
cpu_we  in  1  CPU write strobe, one cycle
cpu_sel  in  2  write target: 0=enable, 1=pending (write-1-to-clear), 2=control, 3=ignored
cpu_wdata  in  NSRC  write data; control uses bits [2:0]
cpu_ack  in  1  acknowledge: clear pending bit irq_id
can_evt  in  NSRC  single-cycle event strobes from the CAN controller
ien  out  NSRC  enable register
pend  out  NSRC  pending register
gie  out  1  control bit0: global interrupt enable
pmode  out  1  control bit1: 0=level, 1=pulse
onoff  out  1  control bit2: controller on/off request
irq  out  1  registered interrupt line
irq_id  out  ID_W  lowest-index active source (registered)
vec_valid  out  1  irq_id is valid (registered)

Behaviour:
- Reset (rst=0, async): ien, pend, control, irq, irq_id, vec_valid all 0; FSM to IDLE; pulse counter 0.
- Register writes take effect at the next clk edge.
- Enable and control registers: plain write.
- Pending register:
  - pend_next[i] = can_evt[i] | (pend[i] & ~clr[i]).
  - clr[i] = (cpu_we & cpu_sel==1 & cpu_wdata[i]) | (cpu_ack & vec_valid & irq_id==i).
  - A set always wins over a clear in the same cycle. No event is lost.
  - CPU and CAN accesses are independent. Simultaneous writes to different registers both succeed.
- active = pend & ien; any = gie & |active. Both are computed from current register values.
- irq_id / vec_valid: priority encode of active (lowest index wins), registered, so 1-cycle latency from active. When any=0: vec_valid=0, irq_id=0. cpu_ack while vec_valid=0 is ignored.
- Level mode (pmode=0): irq <= any, 1-cycle latency. The FSM is held in IDLE.
- Pulse mode (pmode=1) FSM; new = gie & |(active & ~active_q), where active_q is active registered:
  - IDLE: new -> PULSE, load cnt=PULSE_W-1, irq<=1.
  - PULSE: irq=1. If cnt==0 -> HOLD, irq<=0; else cnt--. new events are merged into the current pulse and ignored.
  - HOLD: irq=0. new -> PULSE (reload). any==0 -> IDLE.
  - Pulse width is exactly PULSE_W cycles; PULSE_W=1 gives a one-cycle pulse.
- Changing pmode, or clearing gie: FSM goes to IDLE, and irq=0 from the next edge (level mode then follows any).
- Clearing ien[i] masks source i: pend[i] is kept and re-asserts the interrupt when re-enabled (counts as new in pulse mode).
- onoff has no internal effect; it is exported to the CAN core.

Decomposition:
- Package can_irq_pkg:
  - cpu_sel codes (SEL_IEN=0, SEL_PEND=1, SEL_CTRL=2).
  - Control bit positions (CTRL_GIE=0, CTRL_PMODE=1, CTRL_ONOFF=2).
  - FSM state encoding (IDLE, PULSE, HOLD).
- Sub-module can_irq_prio_enc: parametrised NSRC lowest-index-first encoder, combinational, outputs id and valid. Registering is done in the parent.

Test Plan:
- Reset mid-pulse: NSRC=3, pmode=1, async rst low while irq=1 -> all outputs 0 immediately; FSM IDLE after release.
- Level mode, ien=3'b111, gie=1, can_evt=3'b100 -> pend=100 next cycle; irq=1, irq_id=2, vec_valid=1 one cycle later. Write sel=1 data=100 -> pend=000, then irq=0.
- Set vs clear race: pend[1]=1; same cycle can_evt[1]=1 and W1C data=010 -> pend[1] stays 1. Same result with cpu_ack while irq_id=1.
- Priority/ack: can_evt=3'b110 -> irq_id=1. cpu_ack -> pend=100, irq_id=2. cpu_ack -> vec_valid=0, irq=0.
- Pulse mode, PULSE_W=4: can_evt[0] -> irq high exactly 4 cycles, then low with pend still 1. can_evt[0] again gives no pulse (not new). can_evt[2] -> second 4-cycle pulse.
- Masking: pend=001, ien=000 -> irq=0, vec_valid=0. Write ien=001 -> irq=1 (level), or one 4-cycle pulse (pulse mode). Clear gie mid-pulse -> irq=0 next cycle.
